video_capture_stage: RTL and testbench
======================================

VIDEO_CAPTURE_STAGE -- requirements
Module: video_capture_stage

Interface
REQ-001 SHALL have parameter COLOR_W, default 8, bits per colour channel (8..12).
REQ-002 SHALL have parameter NUM_CH, default 3, colour channel count.
REQ-003 SHALL have parameter H_W, default 12, horizontal counter width.
REQ-004 SHALL have parameter V_W, default 11, vertical counter width.
REQ-005 SHALL have ports:
- ISL_PCLK_i  in  1  capture clock, all logic on rising edge.
- sys_reset_n  in  1  asynchronous, active-low reset.
- pix_i  in  NUM_CH*COLOR_W  raw pixel data.
- hsync_i, vsync_i  in  1 each  raw syncs.
- hs_pol_i, vs_pol_i  in  1 each  input polarity, 1 = active-high.
- h_start_i  in  H_W  first active pixel, counted from HS leading edge.
- h_active_i  in  H_W  active pixels per line.
- v_start_i  in  V_W  first active line, counted from frame start.
- v_active_i  in  V_W  active lines per frame.
- pix_o  out  NUM_CH*COLOR_W  delayed pixel data.
- hsync_o, vsync_o  out  1 each  normalized active-high syncs.
- de_o  out  1  generated data enable.
- xpos_o  out  H_W  active x coordinate.
- ypos_o  out  V_W  active y coordinate.
- htotal_o  out  H_W  measured line length.
- vtotal_o  out  V_W  measured frame length.
- interlace_o  out  1  interlace flag.
- frame_change_o  out  1  one-cycle change pulse.
- locked_o  out  1  measurement valid.

Function
REQ-006 SHALL register pix_i and the syncs in stage 1 and normalize the syncs there: hs = hs_pol_i ? hsync_i : ~hsync_i; vs likewise with vs_pol_i.
REQ-007 SHALL detect the HS leading edge as normalized hs going 0->1 between consecutive stage-1 samples.
REQ-008 SHALL clear hcnt to 0 on the HS leading edge and otherwise increment it, saturating at 2^H_W-1.
REQ-009 SHALL sample vs on each HS leading edge; frame start = sample 1 with previous sample 0.
REQ-010 SHALL clear vcnt to 0 on frame start and otherwise increment it on each HS leading edge, saturating at 2^V_W-1.
REQ-011 SHALL latch htotal_o = hcnt+1 on each HS leading edge, provided hcnt is not saturated.
REQ-012 SHALL, on frame start while in MEASURE or LOCKED, latch vtotal_o = vcnt+1.
REQ-013 SHALL set interlace_o when two consecutive latched vtotal values differ by exactly 1, and clear it when they are equal.
REQ-014 SHALL generate de = (h_start_i <= hcnt < h_start_i+h_active_i) AND (v_start_i <= vcnt < v_start_i+v_active_i).
- Sums SHALL be computed one bit wider, so there is no wrap.
- h_active_i = 0 or v_active_i = 0 SHALL give de = 0.
REQ-015 SHALL output xpos_o = hcnt-h_start_i and ypos_o = vcnt-v_start_i while de = 1, and 0 otherwise.
REQ-016 SHALL give pix_o, hsync_o, vsync_o, de_o, xpos_o and ypos_o an equal, fixed latency of 3 cycles from the input pins.
REQ-017 SHALL implement an FSM with states WAIT_VS, MEASURE and LOCKED:
- WAIT_VS -> MEASURE on first frame start.
- MEASURE -> LOCKED on next frame start; latch totals; pulse frame_change_o.
- LOCKED: pulse frame_change_o on frame start when |vtotal_new - vtotal_prev| > 1, or when htotal at this frame start differs from htotal at the previous frame start.
- Any state -> WAIT_VS when hcnt saturates (sync loss); clear htotal_o, vtotal_o and interlace_o; pulse frame_change_o if leaving LOCKED.
REQ-018 SHALL assert locked_o only in LOCKED.
REQ-019 SHALL give sync loss priority when sync loss and frame start occur in the same cycle.
REQ-020 SHALL sample config inputs continuously, so a change takes effect on the next cycle with no resync.

Reset
REQ-021 SHALL, while sys_reset_n = 0, asynchronously clear every register and output to 0 and the FSM to WAIT_VS.
REQ-022 SHALL, on a reset assertion mid-frame, begin measurement again from WAIT_VS with no frame_change_o pulse.

Structure
REQ-023 SHALL place the FSM state enum and the default parameter constants in shared package video_cap_pkg.
REQ-024 SHALL place edge detection, counters, totals, interlace logic and the FSM in sub-module video_cap_meas; the top level keeps the data pipeline and the DE window.

Verification
REQ-025 Bench SHALL cover: 858x525 progressive, active-low syncs, pols = 0 -> locked_o after 2nd frame start; htotal_o = 858, vtotal_o = 525, interlace_o = 0; exactly one frame_change_o pulse.
REQ-026 Bench SHALL cover: alternating 262/263-line fields -> interlace_o = 1 from the 2nd measured pair; no frame_change_o pulse.
REQ-027 Bench SHALL cover: h_start = 100, h_active = 720, v_start = 20, v_active = 480 -> de_o high for 720 cycles on lines 20..499; xpos_o runs 0..719, 3 cycles after the pins.
REQ-028 Bench SHALL cover: switch 525 to 625 lines while LOCKED -> one frame_change_o pulse at the first 625-line frame start; vtotal_o = 625.
REQ-029 Bench SHALL cover: stop hsync for 4096 cycles -> WAIT_VS; locked_o = 0; totals 0; one frame_change_o pulse.
REQ-030 Bench SHALL cover: reset mid-line -> all outputs 0 immediately; relock after 2 frame starts.

Source files
------------

// File: rtl/video_cap_pkg.sv
// Shared types and default geometry for the video capture stage.
package video_cap_pkg;

  localparam int COLOR_W_DEF = 8;
  localparam int NUM_CH_DEF  = 3;
  localparam int H_W_DEF     = 12;
  localparam int V_W_DEF     = 11;

  // Measurement FSM: wait for a frame start, measure one frame, then track.
  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/video_cap_meas.sv
// Sync edge detection, raster counters, line/frame totals, interlace flag and lock FSM.
// Inputs are the already-registered, normalized stage-1 syncs; hcnt/vcnt align with stage 2.
module video_cap_meas
  import video_cap_pkg::*;
#(
  parameter int H_W = H_W_DEF,
  parameter int V_W = V_W_DEF
) (
  input  logic           ISL_PCLK_i,
  input  logic           sys_reset_n,
  input  logic           hs_i,
  input  logic           vs_i,
  output logic [H_W-1:0] hcnt_o,
  output logic [V_W-1:0] vcnt_o,
  output logic [H_W-1:0] htotal_o,
  output logic [V_W-1:0] vtotal_o,
  output logic           interlace_o,
  output logic           frame_change_o,
  output logic           locked_o
);

  localparam logic [H_W-1:0] H_MAX = '1;
  localparam logic [V_W-1:0] V_MAX = '1;
  localparam logic [H_W-1:0] H_ONE = H_W'(1);
  localparam logic [V_W-1:0] V_ONE = V_W'(1);

  cap_state_e     state, state_n;
  logic           hs_d, vs_samp;
  logic           hs_rise, frame_start, sync_loss;
  logic           lat_v, clr, fc_n;
  logic [H_W-1:0] h_new, h_fs;
  logic [V_W-1:0] v_new, v_diff;

  assign hs_rise     = hs_i & ~hs_d;
  assign frame_start = hs_rise & vs_i & ~vs_samp;
  // A saturated line counter means HS has gone missing.
  assign sync_loss   = (hcnt_o == H_MAX);
  assign h_new       = sync_loss ? htotal_o : hcnt_o + H_ONE;
  assign v_new       = vcnt_o + V_ONE;
  assign v_diff      = (v_new >= vtotal_o) ? v_new - vtotal_o : vtotal_o - v_new;
  assign locked_o    = (state == LOCKED);

  // Previous HS sample for edge detect; VS sampled once per line at the HS edge.
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      hs_d    <= 1'b0;
      vs_samp <= 1'b0;
    end else begin
      hs_d <= hs_i;
      if (hs_rise) vs_samp <= vs_i;
    end
  end

  // Raster counters, both saturating.
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      hcnt_o <= '0;
      vcnt_o <= '0;
    end else begin
      if (hs_rise)         hcnt_o <= '0;
      else if (!sync_loss) hcnt_o <= hcnt_o + H_ONE;
      if (frame_start)                       vcnt_o <= '0;
      else if (hs_rise && vcnt_o != V_MAX)   vcnt_o <= vcnt_o + V_ONE;
    end
  end

  // FSM state register and registered change pulse.
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state          <= WAIT_VS;
      frame_change_o <= 1'b0;
    end else begin
      state          <= state_n;
      frame_change_o <= fc_n;
    end
  end

  // FSM next state; sync loss wins over a coincident frame start.
  always_comb begin
    state_n = state;
    fc_n    = 1'b0;
    lat_v   = 1'b0;
    clr     = 1'b0;
    if (sync_loss) begin
      state_n = WAIT_VS;
      clr     = 1'b1;
      fc_n    = (state == LOCKED);
    end else if (frame_start) begin
      case (state)
        WAIT_VS: state_n = MEASURE;
        MEASURE: begin
          state_n = LOCKED;
          lat_v   = 1'b1;
          fc_n    = 1'b1;
        end
        LOCKED: begin
          lat_v = 1'b1;
          fc_n  = (v_diff > V_ONE) || (h_new != h_fs);
        end
        default: state_n = WAIT_VS;
      endcase
    end
  end

  // Totals, htotal snapshot at frame start, and interlace tracking.
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      htotal_o    <= '0;
      vtotal_o    <= '0;
      h_fs        <= '0;
      interlace_o <= 1'b0;
    end else if (clr) begin
      htotal_o    <= '0;
      vtotal_o    <= '0;
      h_fs        <= '0;
      interlace_o <= 1'b0;
    end else begin
      if (hs_rise) htotal_o <= h_new;
      if (lat_v) begin
        vtotal_o <= v_new;
        h_fs     <= h_new;
        // Only compare against a vtotal that was itself measured.
        if (state == LOCKED) begin
          if (v_diff == V_ONE)   interlace_o <= 1'b1;
          else if (v_diff == '0) interlace_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/video_capture_stage.sv
// Video capture front end: 3-stage data pipeline, timing measurement, DE window.
// Stage 1 registers pins and normalizes syncs, stage 2 aligns with the counters,
// stage 3 registers all video outputs.
module video_capture_stage
  import video_cap_pkg::*;
#(
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int H_W     = H_W_DEF,
  parameter int V_W     = V_W_DEF
) (
  input  logic                      ISL_PCLK_i,
  input  logic                      sys_reset_n,
  input  logic [NUM_CH*COLOR_W-1:0] pix_i,
  input  logic                      hsync_i,
  input  logic                      vsync_i,
  input  logic                      hs_pol_i,
  input  logic                      vs_pol_i,
  input  logic [H_W-1:0]            h_start_i,
  input  logic [H_W-1:0]            h_active_i,
  input  logic [V_W-1:0]            v_start_i,
  input  logic [V_W-1:0]            v_active_i,
  output logic [NUM_CH*COLOR_W-1:0] pix_o,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic                      de_o,
  output logic [H_W-1:0]            xpos_o,
  output logic [V_W-1:0]            ypos_o,
  output logic [H_W-1:0]            htotal_o,
  output logic [V_W-1:0]            vtotal_o,
  output logic                      interlace_o,
  output logic                      frame_change_o,
  output logic                      locked_o
);

  localparam int PW = NUM_CH * COLOR_W;

  logic [PW-1:0]  pix1, pix2;
  logic           hs1, vs1, hs2, vs2;
  logic [H_W-1:0] hcnt;
  logic [V_W-1:0] vcnt;
  logic [H_W:0]   h_end;
  logic [V_W:0]   v_end;
  logic           h_in, v_in, de;

  // Stages 1 and 2: capture pins with sync normalization, then align with counters.
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      pix1 <= '0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      pix2 <= '0;
      hs2  <= 1'b0;
      vs2  <= 1'b0;
    end else begin
      pix1 <= pix_i;
      hs1  <= hs_pol_i ? hsync_i : ~hsync_i;
      vs1  <= vs_pol_i ? vsync_i : ~vsync_i;
      pix2 <= pix1;
      hs2  <= hs1;
      vs2  <= vs1;
    end
  end

  video_cap_meas #(.H_W(H_W), .V_W(V_W)) u_meas (
    .ISL_PCLK_i     (ISL_PCLK_i),
    .sys_reset_n    (sys_reset_n),
    .hs_i           (hs1),
    .vs_i           (vs1),
    .hcnt_o         (hcnt),
    .vcnt_o         (vcnt),
    .htotal_o       (htotal_o),
    .vtotal_o       (vtotal_o),
    .interlace_o    (interlace_o),
    .frame_change_o (frame_change_o),
    .locked_o       (locked_o)
  );

  // Window ends are one bit wider so start+active never wraps; active=0 gives an empty window.
  assign h_end = {1'b0, h_start_i} + {1'b0, h_active_i};
  assign v_end = {1'b0, v_start_i} + {1'b0, v_active_i};
  assign h_in  = (hcnt >= h_start_i) && ({1'b0, hcnt} < h_end);
  assign v_in  = (vcnt >= v_start_i) && ({1'b0, vcnt} < v_end);
  assign de    = h_in && v_in;

  // Stage 3: registered video outputs with active coordinates.
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      pix_o   <= '0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      de_o    <= 1'b0;
      xpos_o  <= '0;
      ypos_o  <= '0;
    end else begin
      pix_o   <= pix2;
      hsync_o <= hs2;
      vsync_o <= vs2;
      de_o    <= de;
      xpos_o  <= de ? hcnt - h_start_i : '0;
      ypos_o  <= de ? vcnt - v_start_i : '0;
    end
  end

endmodule

// File: tb/tb_video_capture_stage.sv
// Randomized bench for video_capture_stage. Stimulus is generated frame by frame;
// expected video outputs come from the raster position of each pin cycle.
module tb_video_capture_stage;

  localparam int HW = 12;
  localparam int VW = 11;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] pix_i = '0;
  logic          hsync_i = 1'b0, vsync_i = 1'b0;
  logic          hs_pol_i = 1'b0, vs_pol_i = 1'b0;
  logic [HW-1:0] h_start_i = '0, h_active_i = '0;
  logic [VW-1:0] v_start_i = '0, v_active_i = '0;
  logic [PW-1:0] pix_o;
  logic          hsync_o, vsync_o, de_o;
  logic [HW-1:0] xpos_o, htotal_o;
  logic [VW-1:0] ypos_o, vtotal_o;
  logic          interlace_o, frame_change_o, locked_o;

  video_capture_stage dut (
    .ISL_PCLK_i(clk), .sys_reset_n(rst_n), .pix_i(pix_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .hs_pol_i(hs_pol_i), .vs_pol_i(vs_pol_i),
    .h_start_i(h_start_i), .h_active_i(h_active_i),
    .v_start_i(v_start_i), .v_active_i(v_active_i),
    .pix_o(pix_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .xpos_o(xpos_o), .ypos_o(ypos_o), .htotal_o(htotal_o), .vtotal_o(vtotal_o),
    .interlace_o(interlace_o), .frame_change_o(frame_change_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int fc_cnt = 0, de_cnt = 0;
  int hlen, hs_w, vs_l, hst, hact, vst, vact;
  int ncyc = 0;
  int fc0, de0;
  logic [63:0] exp_r [4];
  bit          en_r  [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse and DE counters sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_change_o === 1'b1) fc_cnt++;
    if (de_o === 1'b1) de_cnt++;
  end

  task automatic cfg(input int hs, input int ha, input int vs, input int va);
    hst = hs; hact = ha; vst = vs; vact = va;
    h_start_i = HW'(hs); h_active_i = HW'(ha);
    v_start_i = VW'(vs); v_active_i = VW'(va);
  endtask

  // One pin cycle at raster position (x,y); outputs 3 cycles later are checked when en is set.
  task automatic step(input bit ha, input bit va, input int x, input int y, input bit en);
    logic [PW-1:0] p;
    logic [63:0]   g;
    bit            d;
    int            k;
    p = PW'($urandom);
    pix_i   = p;
    hsync_i = hs_pol_i ? ha : ~ha;
    vsync_i = vs_pol_i ? va : ~va;
    d = (hact > 0) && (vact > 0) && (x >= hst) && (x < hst + hact) &&
        (y >= vst) && (y < vst + vact);
    exp_r[ncyc % 4] = {14'd0, p, ha, va, d, d ? HW'(x - hst) : HW'(0),
                       d ? VW'(y - vst) : VW'(0)};
    en_r[ncyc % 4] = en;
    @(posedge clk); #1;
    k = (ncyc + 2) % 4;
    if (ncyc >= 2 && en_r[k]) begin
      g = {14'd0, pix_o, hsync_o, vsync_o, de_o, xpos_o, ypos_o};
      chk("pipe", g, exp_r[k]);
    end
    ncyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, -1, -1, 1'b0);
  endtask

  // HS leading edge at x=0 of each line; VS active for the first vs_l lines.
  task automatic frame(input int lines, input bit en);
    for (int y = 0; y < lines; y++)
      for (int x = 0; x < hlen; x++)
        step(x < hs_w, y < vs_l, x, y, en);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Phase A: 858-pixel lines, active-low syncs, spec DE window with short frames.
    hs_pol_i = 1'b0; vs_pol_i = 1'b0;
    hlen = 858; hs_w = $urandom_range(10, 60); vs_l = $urandom_range(1, 2);
    cfg(100, 720, 2, 6);
    do_reset();
    chk("rst_locked", locked_o, 0);
    chk("rst_htotal", htotal_o, 0);
    idle(5);
    fc0 = fc_cnt;
    frame(10, 1'b0);
    chk("A_unlocked_f1", locked_o, 0);
    frame(10, 1'b0);
    chk("A_locked", locked_o, 1);
    chk("A_htotal", htotal_o, 858);
    chk("A_vtotal", vtotal_o, 10);
    chk("A_interlace", interlace_o, 0);
    chk("A_fc_one", fc_cnt - fc0, 1);
    de0 = de_cnt;
    frame(10, 1'b1);
    chk("A_de_count", de_cnt - de0, 720 * 6);
    chk("A_fc_stable", fc_cnt - fc0, 1);
    // Mid-line reset: everything drops at once, no clock needed.
    for (int x = 0; x < 400; x++) step(x < hs_w, 1'b1, x, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", {htotal_o, vtotal_o, interlace_o, frame_change_o, locked_o,
                        de_o, xpos_o, ypos_o, hsync_o, vsync_o}, 0);
    chk("rst_mid_pix", pix_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Phase B: short lines, 525 -> 625 lines, random polarity, empty H window.
    hs_pol_i = $urandom_range(0, 1) != 0; vs_pol_i = $urandom_range(0, 1) != 0;
    hlen = 8; hs_w = $urandom_range(1, 3); vs_l = $urandom_range(1, 3);
    cfg($urandom_range(0, 7), 0, 0, 100);
    idle(5);
    fc0 = fc_cnt; de0 = de_cnt;
    frame(525, 1'b0);
    chk("B_unlocked_f1", locked_o, 0);
    frame(525, 1'b0);
    chk("B_locked", locked_o, 1);
    chk("B_vtotal525", vtotal_o, 525);
    chk("B_htotal", htotal_o, 8);
    chk("B_fc_lock", fc_cnt - fc0, 1);
    frame(525, 1'b0);
    chk("B_fc_steady", fc_cnt - fc0, 1);
    chk("B_interlace", interlace_o, 0);
    frame(625, 1'b0);
    frame(4, 1'b0);
    chk("B_vtotal625", vtotal_o, 625);
    chk("B_fc_change", fc_cnt - fc0, 2);
    chk("B_still_locked", locked_o, 1);
    chk("B_de_empty", de_cnt - de0, 0);

    // Phase D: HS stops long enough to saturate the line counter.
    fc0 = fc_cnt;
    idle(4200);
    chk("D_unlocked", locked_o, 0);
    chk("D_totals", {htotal_o, vtotal_o}, 0);
    chk("D_interlace", interlace_o, 0);
    chk("D_fc_one", fc_cnt - fc0, 1);

    // Phase C: after reset, alternating 262/263-line fields.
    do_reset();
    chk("C_rst_locked", locked_o, 0);
    hs_w = $urandom_range(1, 3); vs_l = $urandom_range(1, 3);
    cfg($urandom_range(0, 4), 2, 5, 3);
    idle(5);
    frame(262, 1'b0);
    chk("C_unlocked_f1", locked_o, 0);
    fc0 = fc_cnt;
    frame(263, 1'b0);
    chk("C_relock", locked_o, 1);
    chk("C_vtotal262", vtotal_o, 262);
    chk("C_interlace_first", interlace_o, 0);
    fc0 = fc_cnt;
    frame(262, 1'b0);
    chk("C_vtotal263", vtotal_o, 263);
    chk("C_interlace_set", interlace_o, 1);
    frame(263, 1'b0);
    chk("C_interlace_hold", interlace_o, 1);
    frame(4, 1'b0);
    chk("C_interlace_end", interlace_o, 1);
    chk("C_no_fc", fc_cnt - fc0, 0);
    chk("C_locked_end", locked_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
